clock_set_scan: RTL and testbench
=================================

Name: clock_set_scan

Overview:
- Timekeeping and display-feed stage of the alarm clock.
- Keeps hours, minutes and seconds in BCD and runs the RUN/SET_HR/SET_MIN time-setting state machine from two push buttons.
- Time-multiplexes the four HH:MM digits onto a single 4-bit digit bus with a one-hot anode select.
- Drives disp and time_set directly into the digit-blanking (blink) stage; time_set is asserted only while the scanned digit belongs to the field being edited.

Parameters:
- TICKS_PER_SEC, 100, clk_100hz cycles per second; must be >= 2.
- REPEAT_TICKS, 25, cycles between auto-increments while btn_inc is held (used only with AUTO_REPEAT_EN).

Ports:
- clk_100hz  input  1  system clock, 100 Hz.
- rst  input  1  asynchronous, active-high reset.
- btn_mode  input  1  raw mode button, asynchronous to the clock, active-high.
- btn_inc  input  1  raw increment button, asynchronous to the clock, active-high.
- disp  output  4  BCD value of the currently scanned digit.
- an  output  4  active-low anode select, one-hot-low.
- time_set  output  1  high when the scanned digit is in the field being edited.
- hh  output  8  hours BCD {tens,units}, 00-23.
- mm  output  8  minutes BCD {tens,units}, 00-59.

Behaviour:
- One clock: clk_100hz. Reset is asynchronous and active-high: rst.
- Reset values:
  - hh=8'h00, mm=8'h00, seconds=00, prescaler=0.
  - state=RUN, scan index=0.
  - disp=4'h0, an=4'b1111, time_set=0.
  - Button synchronizer and edge-detect flops cleared.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - One pulse per press; latency from raw input to acted-upon edge is 3 cycles.
- Prescaler (RUN only):
  - Counts 0..TICKS_PER_SEC-1 and emits a sec_tick on the wrap.
  - Seconds count 00-59; their wrap carries to minutes; minutes 59 carries to hours.
  - Hours wrap 23->00, so 23:59:59 -> 00:00:00 on one tick.
  - All arithmetic is per-digit BCD; no binary intermediates are exposed.
- State machine (mode edge advances):
  - RUN -> SET_HR -> SET_MIN -> RUN.
  - In SET_HR and SET_MIN the prescaler and seconds are frozen.
  - Leaving SET_MIN to RUN clears seconds and the prescaler to 0.
- Increment edge:
  - SET_HR: hours +1, 23->00.
  - SET_MIN: minutes +1, 59->00, no carry into hours.
  - RUN: the increment edge is ignored.
- Simultaneous events:
  - Mode and increment edges in the same cycle: mode wins, the increment is discarded.
  - A sec_tick coinciding with the RUN->SET_HR mode edge is discarded.
- Scan:
  - Index 0..3 advances every cycle and wraps 3->0.
  - Outputs are registered, all three aligned to the same cycle, one cycle after the index.
  - Index 0: mm units, an=1110.
  - Index 1: mm tens, an=1101.
  - Index 2: hh units, an=1011.
  - Index 3: hh tens, an=0111.
- time_set:
  - 1 when state=SET_HR and index is 2 or 3.
  - 1 when state=SET_MIN and index is 0 or 1.
  - 0 otherwise.
- Reset mid-edit: rst returns the block to RUN at 00:00:00 immediately; an edit in progress is lost.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- With the macro defined:
  - In a set state, btn_inc held synchronized-high starts a hold counter.
  - After 2*REPEAT_TICKS cycles an extra increment fires, then one every REPEAT_TICKS cycles while held.
  - Release or a mode edge clears the hold counter.
- Without the macro: exactly one increment per press; no hold counter is synthesized.

Test Plan:
- Reset release, RUN for 100 cycles -> seconds=01; after 6000 cycles mm=8'h01, hh=8'h00.
- Force 23:59:59 via set mode plus run-up, then one sec_tick -> hh=8'h00, mm=8'h00, seconds=00 on the same edge.
- One mode press, then 25 inc presses -> state SET_HR, hh=8'h01 (23->00->01 wrap); mm unchanged; seconds frozen.
- In SET_MIN with mm=8'h59, one inc -> mm=8'h00, hh unchanged; time_set high only with an=1110 or 1101.
- Mode and inc raw pulses asserted in the same cycle from RUN -> state SET_HR, hh unchanged.
- rst pulsed asynchronously mid-cycle while in SET_MIN at 12:34 -> outputs immediately hh=00, mm=00, an=1111, time_set=0, state RUN.

Source files
------------

// File: rtl/clock_set_scan_if.sv
// Button inputs and display/time outputs of the clock_set_scan timekeeping stage.
interface clock_set_scan_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] disp;
    logic [3:0] an;
    logic       time_set;
    logic [7:0] hh;
    logic [7:0] mm;

    modport master (
        output btn_mode, btn_inc,
        input  disp, an, time_set, hh, mm
    );

    modport slave (
        input  btn_mode, btn_inc,
        output disp, an, time_set, hh, mm
    );
endinterface

// File: rtl/clock_set_scan.sv
// BCD timekeeping, RUN/SET_HR/SET_MIN setting FSM and 4-digit HH:MM scan feed.
// Optional hold-to-repeat on the increment button: define AUTO_REPEAT_EN.
module clock_set_scan #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned REPEAT_TICKS  = 25
) (
    input logic             clk_100hz,
    input logic             rst,
    clock_set_scan_if.slave io
);
    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 2 || REPEAT_TICKS == 0) begin : g_bad_param
        $error("clock_set_scan: TICKS_PER_SEC must be >= 2 and REPEAT_TICKS >= 1");
    end

    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [7:0]         hh_q, hh_d, mm_q, mm_d, sec_q, sec_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         mode_sync_q, inc_sync_q;
    logic               mode_prev_q, inc_prev_q;
    logic [1:0]         idx_q;
    logic [3:0]         disp_q, disp_d, an_q, an_d;
    logic               ts_q, ts_d;
    logic               mode_edge_c, inc_edge_c, inc_fire_c, repeat_fire_c;

    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)            r = 8'h00;
        else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
        else                       r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Shared by minutes and seconds: 00..59 wrap.
    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign mode_edge_c = mode_sync_q[1] & ~mode_prev_q;
    assign inc_edge_c  = inc_sync_q[1] & ~inc_prev_q;
    assign inc_fire_c  = inc_edge_c | repeat_fire_c;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = $clog2(2 * REPEAT_TICKS + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;

    // First repeat after 2*REPEAT_TICKS held cycles, then every REPEAT_TICKS.
    always_comb begin
        hold_d        = hold_q;
        repeat_fire_c = 1'b0;
        if (mode_edge_c || !inc_sync_q[1] || state_q == RUN) begin
            hold_d = '0;
        end else if (hold_q == HOLD_W'(2 * REPEAT_TICKS - 1)) begin
            repeat_fire_c = 1'b1;
            hold_d        = HOLD_W'(REPEAT_TICKS);
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign repeat_fire_c = 1'b0;
`endif

    // Mode edge has priority; it also swallows a coincident increment or sec_tick.
    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        if (mode_edge_c) begin
            unique case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: begin
                    state_d = RUN;
                    sec_d   = 8'h00;
                    presc_d = '0;
                end
                default: state_d = RUN;
            endcase
        end else begin
            unique case (state_q)
                RUN: begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        sec_d   = inc_sixty(sec_q);
                        if (sec_q == 8'h59) begin
                            mm_d = inc_sixty(mm_q);
                            if (mm_q == 8'h59) hh_d = inc_hours(hh_q);
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                SET_HR:  if (inc_fire_c) hh_d = inc_hours(hh_q);
                SET_MIN: if (inc_fire_c) mm_d = inc_sixty(mm_q);
                default: state_d = RUN;
            endcase
        end
    end

    // Scan decode; registered so disp, an and time_set change together.
    always_comb begin
        disp_d = 4'h0;
        an_d   = 4'b1111;
        ts_d   = 1'b0;
        unique case (idx_q)
            2'd0: begin disp_d = mm_q[3:0]; an_d = 4'b1110; ts_d = (state_q == SET_MIN); end
            2'd1: begin disp_d = mm_q[7:4]; an_d = 4'b1101; ts_d = (state_q == SET_MIN); end
            2'd2: begin disp_d = hh_q[3:0]; an_d = 4'b1011; ts_d = (state_q == SET_HR);  end
            default: begin disp_d = hh_q[7:4]; an_d = 4'b0111; ts_d = (state_q == SET_HR); end
        endcase
    end

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            sec_q       <= 8'h00;
            presc_q     <= '0;
            mode_sync_q <= 2'b00;
            inc_sync_q  <= 2'b00;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            idx_q       <= 2'd0;
            disp_q      <= 4'h0;
            an_q        <= 4'b1111;
            ts_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            mode_sync_q <= {mode_sync_q[0], io.btn_mode};
            inc_sync_q  <= {inc_sync_q[0], io.btn_inc};
            mode_prev_q <= mode_sync_q[1];
            inc_prev_q  <= inc_sync_q[1];
            idx_q       <= idx_q + 2'd1;
            disp_q      <= disp_d;
            an_q        <= an_d;
            ts_q        <= ts_d;
        end
    end

    assign io.disp     = disp_q;
    assign io.an       = an_q;
    assign io.time_set = ts_q;
    assign io.hh       = hh_q;
    assign io.mm       = mm_q;
endmodule

// File: tb/tb_clock_set_scan.sv
// Scenario bench for clock_set_scan: timekeeping, setting FSM, wraps and scan feed.
module tb_clock_set_scan;
    localparam int unsigned TPS = 100;

    typedef struct packed {
        logic [3:0] disp;
        logic [3:0] an;
        logic       ts;
    } scan_t;

    logic clk_100hz = 1'b0;
    logic rst       = 1'b1;
    int   total     = 0;
    int   bad       = 0;
    int   cyc;
    scan_t sb_q[$];

    clock_set_scan_if bus();

    clock_set_scan #(.TICKS_PER_SEC(TPS), .REPEAT_TICKS(25)) dut (
        .clk_100hz (clk_100hz),
        .rst       (rst),
        .io        (bus.slave)
    );

    always #5 clk_100hz = ~clk_100hz;

    // Active edges since the last reset; outputs after edge k show scan index (k-1)%4.
    always @(posedge clk_100hz or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic scan_t exp_scan(input int idx, input logic [7:0] h, input logic [7:0] m,
                                       input int st);
        scan_t s;
        case (idx)
            0: begin s.disp = m[3:0]; s.an = 4'b1110; s.ts = (st == 2); end
            1: begin s.disp = m[7:4]; s.an = 4'b1101; s.ts = (st == 2); end
            2: begin s.disp = h[3:0]; s.an = 4'b1011; s.ts = (st == 1); end
            default: begin s.disp = h[7:4]; s.an = 4'b0111; s.ts = (st == 1); end
        endcase
        return s;
    endfunction

    // Raw pulse held long enough to cross the synchronizer; acted on at the third edge.
    task automatic press(input logic m, input logic i);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        repeat (3) @(negedge clk_100hz);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        @(negedge clk_100hz);
    endtask

    task automatic test_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk_100hz);
        total++; if (bus.an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
        total++; if (bus.disp !== 4'h0) begin bad++; $display("FAIL reset_disp got=%h exp=0", bus.disp); end
        total++; if (bus.time_set !== 1'b0) begin bad++; $display("FAIL reset_ts got=%b exp=0", bus.time_set); end
        total++; if ({bus.hh, bus.mm} !== 16'h0000) begin bad++; $display("FAIL reset_time got=%h exp=0000", {bus.hh, bus.mm}); end
        total++; if (2'(dut.state_q) !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", 2'(dut.state_q)); end
        rst = 1'b0;
    endtask

    task automatic test_run_count();
        repeat (100) @(negedge clk_100hz);
        total++; if (dut.sec_q !== 8'h01) begin bad++; $display("FAIL run_sec1 got=%h exp=01", dut.sec_q); end
        repeat (5899) @(negedge clk_100hz);
        total++; if ({bus.hh, bus.mm, dut.sec_q} !== 24'h000059) begin bad++; $display("FAIL run_5999 got=%h exp=000059", {bus.hh, bus.mm, dut.sec_q}); end
        @(negedge clk_100hz);
        total++; if ({bus.hh, bus.mm, dut.sec_q} !== 24'h000100) begin bad++; $display("FAIL run_6000 got=%h exp=000100", {bus.hh, bus.mm, dut.sec_q}); end
        repeat (250) @(negedge clk_100hz);
        total++; if (dut.sec_q !== 8'h02) begin bad++; $display("FAIL run_sec2 got=%h exp=02", dut.sec_q); end
    endtask

    task automatic test_set_hours();
        scan_t got, exp;
        press(1'b1, 1'b0);
        for (int k = 0; k < 25; k++) press(1'b0, 1'b1);
        total++; if (2'(dut.state_q) !== 2'd1) begin bad++; $display("FAIL sethr_state got=%0d exp=1", 2'(dut.state_q)); end
        total++; if ({bus.hh, bus.mm} !== 16'h0101) begin bad++; $display("FAIL sethr_time got=%h exp=0101", {bus.hh, bus.mm}); end
        repeat (300) @(negedge clk_100hz);
        total++; if (dut.sec_q !== 8'h02) begin bad++; $display("FAIL sethr_frozen got=%h exp=02", dut.sec_q); end
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back(exp_scan(cyc % 4, 8'h01, 8'h01, 1));
            @(negedge clk_100hz);
            got = {bus.disp, bus.an, bus.time_set};
            exp = sb_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL sethr_scan got=%h exp=%h", got, exp); end
        end
    endtask

    task automatic test_set_minutes();
        scan_t got, exp;
        press(1'b1, 1'b0);
        for (int k = 0; k < 58; k++) press(1'b0, 1'b1);
        total++; if ({bus.hh, bus.mm} !== 16'h0159) begin bad++; $display("FAIL setmin_59 got=%h exp=0159", {bus.hh, bus.mm}); end
        press(1'b0, 1'b1);
        total++; if ({bus.hh, bus.mm} !== 16'h0100) begin bad++; $display("FAIL setmin_wrap got=%h exp=0100", {bus.hh, bus.mm}); end
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back(exp_scan(cyc % 4, 8'h01, 8'h00, 2));
            @(negedge clk_100hz);
            got = {bus.disp, bus.an, bus.time_set};
            exp = sb_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL setmin_scan got=%h exp=%h", got, exp); end
        end
    endtask

    task automatic test_midnight_wrap();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int k = 0; k < 22; k++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int k = 0; k < 59; k++) press(1'b0, 1'b1);
        total++; if ({bus.hh, bus.mm} !== 16'h2359) begin bad++; $display("FAIL mid_set got=%h exp=2359", {bus.hh, bus.mm}); end
        press(1'b1, 1'b0);
        repeat (5998) @(negedge clk_100hz);
        total++; if ({bus.hh, bus.mm, dut.sec_q} !== 24'h235959) begin bad++; $display("FAIL mid_pre got=%h exp=235959", {bus.hh, bus.mm, dut.sec_q}); end
        @(negedge clk_100hz);
        total++; if ({bus.hh, bus.mm, dut.sec_q} !== 24'h000000) begin bad++; $display("FAIL mid_wrap got=%h exp=000000", {bus.hh, bus.mm, dut.sec_q}); end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1);
        total++; if (2'(dut.state_q) !== 2'd1) begin bad++; $display("FAIL simul_state got=%0d exp=1", 2'(dut.state_q)); end
        total++; if (bus.hh !== 8'h00) begin bad++; $display("FAIL simul_hh got=%h exp=00", bus.hh); end
    endtask

    task automatic test_reset_mid_edit();
        scan_t got, exp;
        for (int k = 0; k < 12; k++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int k = 0; k < 34; k++) press(1'b0, 1'b1);
        total++; if ({bus.hh, bus.mm} !== 16'h1234) begin bad++; $display("FAIL edit_time got=%h exp=1234", {bus.hh, bus.mm}); end
        total++; if (2'(dut.state_q) !== 2'd2) begin bad++; $display("FAIL edit_state got=%0d exp=2", 2'(dut.state_q)); end
        @(posedge clk_100hz);
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.hh, bus.mm} !== 16'h0000) begin bad++; $display("FAIL rstmid_time got=%h exp=0000", {bus.hh, bus.mm}); end
        total++; if (bus.an !== 4'b1111) begin bad++; $display("FAIL rstmid_an got=%b exp=1111", bus.an); end
        total++; if (bus.time_set !== 1'b0) begin bad++; $display("FAIL rstmid_ts got=%b exp=0", bus.time_set); end
        total++; if (2'(dut.state_q) !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", 2'(dut.state_q)); end
        total++; if (dut.sec_q !== 8'h00) begin bad++; $display("FAIL rstmid_sec got=%h exp=00", dut.sec_q); end
        @(negedge clk_100hz);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(exp_scan(cyc % 4, 8'h00, 8'h00, 0));
            @(negedge clk_100hz);
            got = {bus.disp, bus.an, bus.time_set};
            exp = sb_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL rstmid_scan got=%h exp=%h", got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_set_hours();
        test_set_minutes();
        test_midnight_wrap();
        test_simultaneous();
        test_reset_mid_edit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
